li_expander: RTL and testbench

Sequential `li` pseudo-instruction expander for the pipelined CPU's instruction-memory loader path. It accepts a destination register and a 32-bit constant, then emits the minimal RV32I sequence that materialises that constant. The sequence is a single `ADDI`, a single `LUI`, or `LUI`+`ADDI`. Each instruction word is emitted over a valid/ready stream together with an auto-incrementing instruction-memory address. It performs the inverse of the decode-stage immediate extender: splitting a 32-bit value into U-type and I-type immediate fields, with carry compensation.

---
 rtl/li_expander_pkg.sv | 32 +++
 rtl/li_expander_if.sv | 34 +++
 rtl/li_split.sv | 26 ++
 rtl/li_expander.sv | 134 +++++++++++++
 tb/tb_li_expander.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/li_expander_pkg.sv
// -----------------------------------------------------------------------------
// li_expander_pkg
// Shared definitions for the `li` pseudo-instruction expander: RV32I opcode
// and funct3 constants, the expander state encoding, and instruction-word
// encoders for the two instruction formats the expander emits.
// -----------------------------------------------------------------------------
package li_expander_pkg;

   localparam logic [6:0] OP_LUI      = 7'b0110111;
   localparam logic [6:0] OP_ADDI     = 7'b0010011;
   localparam logic [2:0] FUNCT3_ADDI = 3'b000;

   typedef enum logic [1:0] {
      LI_IDLE      = 2'd0,
      LI_EMIT_LUI  = 2'd1,
      LI_EMIT_ADDI = 2'd2
   } li_state_t;

   // U-type: LUI rd, hi
   function automatic logic [31:0] enc_lui(input logic [19:0] hi,
                                           input logic [4:0]  rd);
      return {hi, rd, OP_LUI};
   endfunction

   // I-type: ADDI rd, rs1, lo
   function automatic logic [31:0] enc_addi(input logic [11:0] lo,
                                            input logic [4:0]  rs1,
                                            input logic [4:0]  rd);
      return {lo, rs1, FUNCT3_ADDI, rd, OP_ADDI};
   endfunction

endpackage

// File: rtl/li_expander_if.sv
// -----------------------------------------------------------------------------
// li_expander_if
// Request and output streams of the li expander.
//   base_load/base_addr : start-address load for the instruction counter
//   req_*               : request stream (rd + 32-bit constant), valid/ready
//   out_*               : emitted instruction word + address, valid/ready
// Modports: master = request producer / word consumer, slave = expander.
// -----------------------------------------------------------------------------
interface li_expander_if #(
   parameter int ADDR_W = 32
);
   logic              base_load;
   logic [ADDR_W-1:0] base_addr;

   logic              req_valid;
   logic              req_ready;
   logic [4:0]        req_rd;
   logic [31:0]       req_imm;

   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [ADDR_W-1:0] out_addr;

   modport master (
      output base_load, base_addr, req_valid, req_rd, req_imm, out_ready,
      input  req_ready, out_valid, out_instr, out_addr
   );

   modport slave (
      input  base_load, base_addr, req_valid, req_rd, req_imm, out_ready,
      output req_ready, out_valid, out_instr, out_addr
   );
endinterface

// File: rtl/li_split.sv
// -----------------------------------------------------------------------------
// li_split
// Combinational split of a 32-bit constant into LUI/ADDI immediates.
//   imm       in  32 : constant to materialise
//   hi        out 20 : U-type immediate, pre-compensated for ADDI sign extension
//   lo        out 12 : I-type immediate
//   need_lui  out 1  : constant does not fit a signed 12-bit immediate
//   need_addi out 1  : an ADDI is required (sole word, or non-zero low part)
// -----------------------------------------------------------------------------
module li_split (
   input  logic [31:0] imm,
   output logic [19:0] hi,
   output logic [11:0] lo,
   output logic        need_lui,
   output logic        need_addi
);
   logic fits12;

   assign lo = imm[11:0];
   // ADDI sign-extends lo, so a set bit 11 subtracts 4096; add it back into hi.
   assign hi = imm[31:12] + {19'd0, imm[11]};

   assign fits12    = (&imm[31:11]) | ~(|imm[31:11]);
   assign need_lui  = ~fits12;
   assign need_addi = fits12 | (|imm[11:0]);
endmodule

// File: rtl/li_expander.sv
// -----------------------------------------------------------------------------
// li_expander
// Expands `li rd, imm` into the minimal RV32I sequence (ADDI, LUI, or
// LUI+ADDI) and streams the words out with auto-incrementing addresses.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : li_expander_if.slave (request in, instruction words out)
//   done       : one-cycle pulse after a request finishes (or rd==0 accept)
//   emit_count : words handshaked since reset, wrapping
// -----------------------------------------------------------------------------
module li_expander
   import li_expander_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   li_expander_if.slave     bus,
   output logic             done,
   output logic [CNT_W-1:0] emit_count
);

   li_state_t         state;
   logic [ADDR_W-1:0] addr_q;
   logic [11:0]       lo_q;
   logic [4:0]        rd_q;
   logic              addi_q;

   logic              out_valid_q;
   logic [31:0]       out_instr_q;
   logic [ADDR_W-1:0] out_addr_q;

   logic [19:0]       s_hi;
   logic [11:0]       s_lo;
   logic              s_need_lui;
   logic              s_need_addi;

   logic              req_fire;
   logic              out_fire;
   logic [ADDR_W-1:0] start_addr;

   li_split u_split (
      .imm       (bus.req_imm),
      .hi        (s_hi),
      .lo        (s_lo),
      .need_lui  (s_need_lui),
      .need_addi (s_need_addi)
   );

   assign bus.req_ready = (state == LI_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_instr = out_instr_q;
   assign bus.out_addr  = out_addr_q;

   assign req_fire = bus.req_valid & bus.req_ready;
   assign out_fire = out_valid_q & bus.out_ready;

   // A base load in the same cycle as a request supplies that request's
   // first address.
   assign start_addr = bus.base_load ? (bus.base_addr & ~ADDR_W'(3)) : addr_q;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // right-hand side below reads the pre-edge value of each register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= LI_IDLE;
         addr_q      <= '0;
         lo_q        <= '0;
         rd_q        <= '0;
         addi_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_addr_q  <= '0;
         done        <= 1'b0;
         emit_count  <= '0;
      end else begin
         done <= 1'b0;

         if (out_fire) begin
            emit_count <= emit_count + CNT_W'(1);
            addr_q     <= addr_q + ADDR_W'(4);
         end

         case (state)
            LI_IDLE: begin
               if (bus.base_load) addr_q <= start_addr;
               if (req_fire) begin
                  lo_q   <= s_lo;
                  rd_q   <= bus.req_rd;
                  addi_q <= s_need_addi;
                  if (bus.req_rd == 5'd0) begin
                     done <= 1'b1;
                  end else if (s_need_lui) begin
                     out_valid_q <= 1'b1;
                     out_instr_q <= enc_lui(s_hi, bus.req_rd);
                     out_addr_q  <= start_addr;
                     state       <= LI_EMIT_LUI;
                  end else begin
                     out_valid_q <= 1'b1;
                     out_instr_q <= enc_addi(s_lo, 5'd0, bus.req_rd);
                     out_addr_q  <= start_addr;
                     state       <= LI_EMIT_ADDI;
                  end
               end
            end

            LI_EMIT_LUI: begin
               if (out_fire) begin
                  if (addi_q) begin
                     out_instr_q <= enc_addi(lo_q, rd_q, rd_q);
                     out_addr_q  <= addr_q + ADDR_W'(4);
                     state       <= LI_EMIT_ADDI;
                  end else begin
                     out_valid_q <= 1'b0;
                     done        <= 1'b1;
                     state       <= LI_IDLE;
                  end
               end
            end

            LI_EMIT_ADDI: begin
               if (out_fire) begin
                  out_valid_q <= 1'b0;
                  done        <= 1'b1;
                  state       <= LI_IDLE;
               end
            end

            default: state <= LI_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_li_expander.sv
// -----------------------------------------------------------------------------
// tb_li_expander
// Self-checking bench for li_expander: directed cases plus randomized
// requests against an arithmetic reference model of the li expansion.
// -----------------------------------------------------------------------------
module tb_li_expander;

   localparam int ADDR_W = 32;
   localparam int CNT_W  = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             done;
   logic [CNT_W-1:0] emit_count;

   li_expander_if #(.ADDR_W(ADDR_W)) bus ();

   li_expander #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .done       (done),
      .emit_count (emit_count)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] m_addr;
   int unsigned m_count;
   logic [31:0] got_instr[$];
   logic [31:0] got_addr[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_lui(input logic [31:0] hi, input logic [31:0] rd);
      return hi * 32'd4096 + rd * 32'd128 + 32'h37;
   endfunction

   function automatic logic [31:0] m_addi(input logic [31:0] lo, input logic [31:0] rs1,
                                          input logic [31:0] rd);
      return lo * 32'h0010_0000 + rs1 * 32'd32768 + rd * 32'd128 + 32'h13;
   endfunction

   // Issue one request and consume its words. fixed_stall >= 0 holds
   // out_ready low that many cycles on the first word; otherwise stalls are
   // random with probability stall_pct percent.
   task automatic do_req(input logic [4:0] rd, input logic [31:0] imm, input bit bl,
                         input logic [31:0] ba, input int fixed_stall, input int stall_pct);
      logic [31:0] ew[$];
      logic [31:0] hi;
      logic [31:0] lo;
      int          s;
      int          guard;
      int          stalls;
      bit          rdy;
      bit          hs;

      got_instr.delete();
      got_addr.delete();
      s  = $signed(imm);
      lo = imm & 32'hFFF;
      if (rd != 5'd0) begin
         if (s >= -2048 && s <= 2047) begin
            ew.push_back(m_addi(lo, 0, 32'(rd)));
         end else begin
            hi = (imm + 32'h800) >> 12;
            ew.push_back(m_lui(hi, 32'(rd)));
            if (lo != 0) ew.push_back(m_addi(lo, 32'(rd), 32'(rd)));
         end
      end
      if (bl) m_addr = ba & ~32'h3;

      guard = 0;
      while (!bus.req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("req_ready_idle", bus.req_ready, 1);

      bus.req_valid = 1'b1;
      bus.req_rd    = rd;
      bus.req_imm   = imm;
      bus.base_load = bl;
      bus.base_addr = ba;
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.base_load = 1'b0;
      check("req_ready_after_accept", bus.req_ready, (rd == 5'd0));

      for (int i = 0; i < ew.size(); i++) begin
         stalls = 0;
         hs     = 1'b0;
         while (!hs) begin
            check("out_valid", bus.out_valid, 1);
            check("out_instr", bus.out_instr, ew[i]);
            check("out_addr", bus.out_addr, m_addr);
            check("done_mid", done, 0);
            if (fixed_stall >= 0) rdy = (i > 0) || (stalls >= fixed_stall);
            else                  rdy = ($urandom_range(99) >= stall_pct) || (stalls >= 6);
            bus.out_ready = rdy;
            // base_load outside IDLE must be ignored
            bus.base_load = 1'($urandom_range(1));
            bus.base_addr = $urandom;
            @(negedge clk);
            if (rdy) begin
               got_instr.push_back(ew[i]);
               got_addr.push_back(m_addr);
               m_addr  = m_addr + 32'd4;
               m_count = m_count + 1;
               hs      = 1'b1;
            end else begin
               stalls++;
            end
         end
      end
      bus.out_ready = 1'b0;
      bus.base_load = 1'b0;
      check("done_pulse", done, 1);
      check("out_valid_end", bus.out_valid, 0);
      check("emit_count", emit_count, m_count[CNT_W-1:0]);
      @(negedge clk);
      check("done_one_cycle", done, 0);
   endtask

   task automatic rand_imm(output logic [31:0] imm);
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(3))
         0: imm = 32'($urandom_range(4095)) - 32'd2048;
         1: imm = {r[19:0], 12'h000};
         2: imm = r;
         default: begin
            case ($urandom_range(5))
               0: imm = 32'h0000_07FF;
               1: imm = 32'hFFFF_F7FF;
               2: imm = 32'h0000_0800;
               3: imm = 32'h7FFF_F800;
               4: imm = 32'h8000_0000;
               default: imm = 32'hFFFF_FFFF;
            endcase
         end
      endcase
   endtask

   initial begin
      logic [31:0] imm;
      logic [4:0]  rd;

      rst           = 1'b1;
      bus.base_load = 1'b0;
      bus.base_addr = '0;
      bus.req_valid = 1'b0;
      bus.req_rd    = '0;
      bus.req_imm   = '0;
      bus.out_ready = 1'b0;
      m_addr        = '0;
      m_count       = 0;

      repeat (2) @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_instr", bus.out_instr, 0);
      check("rst_out_addr", bus.out_addr, 0);
      check("rst_done", done, 0);
      check("rst_emit_count", emit_count, 0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_req_ready", bus.req_ready, 1);

      // Two-word case
      do_req(5'd5, 32'h1234_5678, 1'b0, '0, 0, 0);
      check("tp1_n", got_instr.size(), 2);
      check("tp1_w0", got_instr[0], 32'h1234_52B7);
      check("tp1_w1", got_instr[1], 32'h6782_8293);
      check("tp1_a0", got_addr[0], 32'h0);
      check("tp1_a1", got_addr[1], 32'h4);

      // Fits 12 bits (negative), then the carry path
      do_req(5'd1, 32'hFFFF_F800, 1'b0, '0, 0, 0);
      check("tp2_n", got_instr.size(), 1);
      check("tp2_w0", got_instr[0], 32'h8000_0093);
      do_req(5'd1, 32'h0000_0800, 1'b0, '0, 0, 0);
      check("tp3_w0", got_instr[0], 32'h0000_10B7);
      check("tp3_w1", got_instr[1], 32'h8000_8093);

      // LUI only, then rd==0
      do_req(5'd2, 32'hABCD_E000, 1'b0, '0, 0, 0);
      check("tp4_n", got_instr.size(), 1);
      check("tp4_w0", got_instr[0], 32'hABCD_E137);
      do_req(5'd0, 32'h1234_5678, 1'b0, '0, 0, 0);
      check("tp5_no_out", bus.out_valid, 0);

      // Base load plus 3-cycle stall on the first word
      do_req(5'd3, 32'h7FFF_F800, 1'b1, 32'h0000_0100, 3, 0);
      check("tp6_w0", got_instr[0], 32'h8000_01B7);
      check("tp6_a0", got_addr[0], 32'h0000_0100);
      check("tp6_w1", got_instr[1], 32'h8001_8193);
      check("tp6_a1", got_addr[1], 32'h0000_0104);

      // Address wrap; low base bits are dropped
      do_req(5'd9, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, -1, 30);
      check("tp7_a0", got_addr[0], 32'hFFFF_FFFC);
      check("tp7_a1", got_addr[1], 32'h0000_0000);

      // Randomized requests
      for (int n = 0; n < 60; n++) begin
         rd = 5'($urandom_range(31));
         rand_imm(imm);
         do_req(rd, imm, ($urandom_range(7) == 0), $urandom, -1, $urandom_range(70));
      end

      // Reset while the ADDI word is pending
      bus.req_valid = 1'b1;
      bus.req_rd    = 5'd7;
      bus.req_imm   = 32'h1234_5678;
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("mid_valid_before_rst", bus.out_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_out_instr", bus.out_instr, 0);
      check("mid_rst_out_addr", bus.out_addr, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_emit_count", emit_count, 0);
      @(negedge clk);
      rst     = 1'b0;
      m_addr  = '0;
      m_count = 0;
      @(negedge clk);
      check("post_rst_no_done", done, 0);
      do_req(5'd4, 32'hDEAD_BEEF, 1'b0, '0, -1, 20);
      check("post_rst_a0", got_addr[0], 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
